// File: rtl/cmd_issue_ctrl_pkg.sv
// Shared types and constants for the SD CMD-line issue controller.
package sdhost_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } cmd_state_e;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_136  = 2'b01;
  localparam logic [1:0] RESP_48   = 2'b10;
  localparam logic [1:0] RESP_48B  = 2'b11;

  localparam int INT_CMD_COMPLETE = 0;
  localparam int INT_TIMEOUT      = 1;
  localparam int INT_CRC          = 2;
  localparam int INT_INDEX        = 3;

  // 136-bit responses are captured through the same 48-bit window.
  function automatic logic resp_captured(input logic [1:0] rt);
    logic cap;
    case (rt)
      RESP_NONE:                   cap = 1'b0;
      RESP_136, RESP_48, RESP_48B: cap = 1'b1;
      default:                     cap = 1'b0;
    endcase
    return cap;
  endfunction

endpackage

// File: rtl/cmd_issue_ctrl_if.sv
// Register-block and CMD-phy signals of the issue controller.
interface cmd_issue_ctrl_if #(
  parameter int RESP_W = 48
);
  logic              reg_wr_cmd;
  logic [5:0]        cmd_index_in;
  logic [1:0]        cmd_type_in;
  logic              data_present_in;
  logic              index_check_en_in;
  logic              crc_check_en_in;
  logic [1:0]        resp_type_in;
  logic [31:0]       argument_in;
  logic              timeout_en_in;
  logic              sw_rst_cmd;
  logic [3:0]        int_clr;
  logic              command_complete;
  logic              command_index_error;
  logic              phy_crc_error;
  logic [RESP_W-1:0] response;
  logic              new_command;
  logic [31:0]       cmd_argument;
  logic [5:0]        cmd_index;
  logic              timeout_enable;
  logic              cmd_inhibit;
  logic [31:0]       resp_reg;
  logic [3:0]        int_status;
  logic              cmd_dropped;

  modport master (
    output reg_wr_cmd, cmd_index_in, cmd_type_in, data_present_in,
           index_check_en_in, crc_check_en_in, resp_type_in, argument_in,
           timeout_en_in, sw_rst_cmd, int_clr, command_complete,
           command_index_error, phy_crc_error, response,
    input  new_command, cmd_argument, cmd_index, timeout_enable,
           cmd_inhibit, resp_reg, int_status, cmd_dropped
  );

  modport slave (
    input  reg_wr_cmd, cmd_index_in, cmd_type_in, data_present_in,
           index_check_en_in, crc_check_en_in, resp_type_in, argument_in,
           timeout_en_in, sw_rst_cmd, int_clr, command_complete,
           command_index_error, phy_crc_error, response,
    output new_command, cmd_argument, cmd_index, timeout_enable,
           cmd_inhibit, resp_reg, int_status, cmd_dropped
  );
endinterface

// File: rtl/cmd_watchdog.sv
// Saturating cycle counter flagging the last cycle before a command timeout.
module cmd_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_ONE;
    end
  end

  assign o_expired = (r_count == CNT_LAST);
endmodule

// File: rtl/cmd_issue_ctrl.sv
// SD CMD-line sequencer: accepts a command write, launches it on the phy,
// waits for completion or timeout and maintains response and W1C status.
module cmd_issue_ctrl
  import sdhost_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int RESP_W         = 48
) (
  input logic             clock,
  input logic             reset,
  cmd_issue_ctrl_if.slave bus
);
  cmd_state_e  r_state;
  cmd_state_e  w_state_next;

  logic [31:0] r_argument;
  logic [5:0]  r_index;
  logic [1:0]  r_cmd_type;
  logic        r_data_present;
  logic        r_index_chk;
  logic        r_crc_chk;
  logic [1:0]  r_resp_type;
  logic        r_timeout_en;
  logic [31:0] r_resp;
  logic [3:0]  r_status;
  logic        r_dropped;

  logic        w_in_wait;
  logic        w_accept;
  logic        w_complete;
  logic        w_timeout;
  logic        w_expired;
  logic        w_new_command;
  logic        w_inhibit;
  logic [3:0]  w_set;
  logic        w_unused_bits;

  assign w_in_wait  = (r_state == ST_WAIT);
  assign w_accept   = bus.reg_wr_cmd && (r_state == ST_IDLE) && !bus.sw_rst_cmd;
  assign w_complete = w_in_wait && bus.command_complete && !bus.sw_rst_cmd;
  // A completion in the expiry cycle takes priority over the timeout.
  assign w_timeout  = w_in_wait && !bus.command_complete && r_timeout_en &&
                      w_expired && !bus.sw_rst_cmd;

  cmd_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_clear  (!w_in_wait || bus.sw_rst_cmd),
    .i_enable (w_in_wait),
    .o_expired(w_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.sw_rst_cmd) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (bus.reg_wr_cmd) w_state_next = ST_LAUNCH;
        ST_LAUNCH: w_state_next = ST_WAIT;
        ST_WAIT:   if (bus.command_complete || w_timeout) w_state_next = ST_DONE;
        ST_DONE:   w_state_next = ST_IDLE;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  // The launch pulse is squashed combinationally by a CMD-line abort.
  always_comb begin
    w_new_command = 1'b0;
    w_inhibit     = 1'b1;
    case (r_state)
      ST_IDLE:   w_inhibit = 1'b0;
      ST_LAUNCH: w_new_command = !bus.sw_rst_cmd;
      default:   w_inhibit = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_argument     <= '0;
      r_index        <= '0;
      r_cmd_type     <= '0;
      r_data_present <= 1'b0;
      r_index_chk    <= 1'b0;
      r_crc_chk      <= 1'b0;
      r_resp_type    <= RESP_NONE;
      r_timeout_en   <= 1'b0;
    end else if (w_accept) begin
      r_argument     <= bus.argument_in;
      r_index        <= bus.cmd_index_in;
      r_cmd_type     <= bus.cmd_type_in;
      r_data_present <= bus.data_present_in;
      r_index_chk    <= bus.index_check_en_in;
      r_crc_chk      <= bus.crc_check_en_in;
      r_resp_type    <= bus.resp_type_in;
      r_timeout_en   <= bus.timeout_en_in;
    end
  end

  always_comb begin
    w_set = '0;
    if (w_complete) begin
      w_set[INT_CMD_COMPLETE] = 1'b1;
      w_set[INT_INDEX]        = r_index_chk && bus.command_index_error;
      w_set[INT_CRC]          = r_crc_chk && bus.phy_crc_error;
    end
    if (w_timeout) begin
      w_set[INT_TIMEOUT] = 1'b1;
    end
  end

  // Sticky bits: a same-cycle set beats the W1C strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~bus.int_clr) | w_set;
      if (bus.sw_rst_cmd) begin
        r_status[INT_CMD_COMPLETE] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_resp    <= '0;
      r_dropped <= 1'b0;
    end else begin
      if (w_complete && resp_captured(r_resp_type)) begin
        r_resp <= bus.response[39:8];
      end
      r_dropped <= bus.reg_wr_cmd && (r_state != ST_IDLE) && !bus.sw_rst_cmd;
    end
  end

  // Command type and data-present are held for readback only.
  assign w_unused_bits = ^{r_cmd_type, r_data_present,
                           bus.response[RESP_W-1:40], bus.response[7:0]};

  assign bus.new_command    = w_new_command;
  assign bus.cmd_argument   = r_argument;
  assign bus.cmd_index      = r_index;
  assign bus.timeout_enable = r_timeout_en;
  assign bus.cmd_inhibit    = w_inhibit;
  assign bus.resp_reg       = r_resp;
  assign bus.int_status     = r_status;
  assign bus.cmd_dropped    = r_dropped;
endmodule

// File: tb/tb_cmd_issue_ctrl.sv
// Directed self-checking bench for cmd_issue_ctrl.
module tb_cmd_issue_ctrl;
  localparam int TO = 64;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   nc_count = 0;

  always #5 clock = ~clock;

  cmd_issue_ctrl_if #(.RESP_W(48)) bus ();

  cmd_issue_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .RESP_W(48)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
    if (bus.new_command) nc_count++;
  endtask

  task automatic issue(input logic [5:0] idx, input logic [1:0] rt, input logic ichk,
                       input logic cchk, input logic ten, input logic [31:0] arg);
    bus.cmd_index_in      = idx;
    bus.resp_type_in      = rt;
    bus.index_check_en_in = ichk;
    bus.crc_check_en_in   = cchk;
    bus.timeout_en_in     = ten;
    bus.argument_in       = arg;
    bus.cmd_type_in       = 2'b00;
    bus.data_present_in   = 1'b0;
    bus.reg_wr_cmd        = 1'b1;
    tick();
    bus.reg_wr_cmd  = 1'b0;
    bus.argument_in = ~arg;
    bus.cmd_index_in = ~idx;
    $display("cmd write: idx=%0d rt=%b ichk=%b cchk=%b ten=%b arg=%h", idx, rt, ichk, cchk, ten, arg);
  endtask

  task automatic clear_status();
    bus.int_clr = 4'hF;
    tick();
    bus.int_clr = 4'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.reg_wr_cmd = 0; bus.cmd_index_in = 0; bus.cmd_type_in = 0; bus.data_present_in = 0;
    bus.index_check_en_in = 0; bus.crc_check_en_in = 0; bus.resp_type_in = 0;
    bus.argument_in = 0; bus.timeout_en_in = 0; bus.sw_rst_cmd = 0; bus.int_clr = 0;
    bus.command_complete = 0; bus.command_index_error = 0; bus.phy_crc_error = 0;
    bus.response = '0;
    repeat (3) tick();
    total++;
    if ({bus.new_command, bus.cmd_argument, bus.cmd_index, bus.timeout_enable, bus.cmd_inhibit,
         bus.resp_reg, bus.int_status, bus.cmd_dropped} !== 78'd0) begin
      bad++;
      $display("FAIL reset_outputs: inhibit=%b status=%b resp=%h arg=%h idx=%0d nc=%b drop=%b want all 0",
               bus.cmd_inhibit, bus.int_status, bus.resp_reg, bus.cmd_argument, bus.cmd_index,
               bus.new_command, bus.cmd_dropped);
    end
    reset = 1'b0;
    tick();
    total++;
    if (bus.cmd_inhibit !== 1'b0) begin bad++; $display("FAIL reset_idle: inhibit=%b want 0", bus.cmd_inhibit); end
    $display("reset test complete");
  endtask

  task automatic test_nominal();
    nc_count = 0;
    issue(6'd8, 2'b10, 1'b0, 1'b0, 1'b0, 32'h000001AA);
    total++;
    if (bus.new_command !== 1'b1 || bus.cmd_inhibit !== 1'b1) begin
      bad++; $display("FAIL nominal_launch: nc=%b inhibit=%b want 1 1", bus.new_command, bus.cmd_inhibit);
    end
    total++;
    if (bus.cmd_index !== 6'd8 || bus.cmd_argument !== 32'h000001AA) begin
      bad++; $display("FAIL nominal_latch: idx=%0d arg=%h want 8 000001aa", bus.cmd_index, bus.cmd_argument);
    end
    for (int i = 2; i <= 6; i++) begin
      tick();
      total++;
      if (bus.new_command !== 1'b0 || bus.cmd_inhibit !== 1'b1) begin
        bad++; $display("FAIL nominal_wait_c%0d: nc=%b inhibit=%b want 0 1", i, bus.new_command, bus.cmd_inhibit);
      end
    end
    tick();
    bus.command_complete = 1'b1;
    bus.response = 48'h08000001AA01;
    tick();
    bus.command_complete = 1'b0;
    bus.response = '0;
    total++;
    if (bus.int_status !== 4'b0001 || bus.resp_reg !== 32'h000001AA || bus.cmd_inhibit !== 1'b1) begin
      bad++; $display("FAIL nominal_done: status=%b resp=%h inhibit=%b want 0001 000001aa 1",
                      bus.int_status, bus.resp_reg, bus.cmd_inhibit);
    end
    tick();
    total++;
    if (bus.cmd_inhibit !== 1'b0 || nc_count !== 1) begin
      bad++; $display("FAIL nominal_release: inhibit=%b launches=%0d want 0 1", bus.cmd_inhibit, nc_count);
    end
  endtask

  task automatic test_timeout();
    clear_status();
    issue(6'd17, 2'b10, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    total++;
    if (bus.timeout_enable !== 1'b1) begin bad++; $display("FAIL timeout_latch: ten=%b want 1", bus.timeout_enable); end
    bus.response = 48'hFFFFFFFFFFFF;
    repeat (TO) tick();
    total++;
    if (bus.int_status !== 4'b0000 || bus.cmd_inhibit !== 1'b1) begin
      bad++; $display("FAIL timeout_early: status=%b inhibit=%b want 0000 1", bus.int_status, bus.cmd_inhibit);
    end
    tick();
    total++;
    if (bus.int_status !== 4'b0010 || bus.resp_reg !== 32'h000001AA || bus.cmd_inhibit !== 1'b1) begin
      bad++; $display("FAIL timeout_flag: status=%b resp=%h inhibit=%b want 0010 000001aa 1",
                      bus.int_status, bus.resp_reg, bus.cmd_inhibit);
    end
    tick();
    bus.response = '0;
    total++;
    if (bus.cmd_inhibit !== 1'b0) begin bad++; $display("FAIL timeout_release: inhibit=%b want 0", bus.cmd_inhibit); end
  endtask

  task automatic test_errors();
    clear_status();
    issue(6'd3, 2'b10, 1'b1, 1'b1, 1'b0, 32'h00000055);
    tick();
    bus.command_complete = 1'b1; bus.command_index_error = 1'b1; bus.phy_crc_error = 1'b1;
    bus.response = 48'h0312345678AB;
    tick();
    bus.command_complete = 1'b0; bus.command_index_error = 1'b0; bus.phy_crc_error = 1'b0;
    total++;
    if (bus.int_status !== 4'b1101 || bus.resp_reg !== 32'h12345678) begin
      bad++; $display("FAIL errors_checked: status=%b resp=%h want 1101 12345678", bus.int_status, bus.resp_reg);
    end
    tick();
    clear_status();
    issue(6'd3, 2'b00, 1'b0, 1'b0, 1'b0, 32'h00000066);
    tick();
    bus.command_complete = 1'b1; bus.command_index_error = 1'b1; bus.phy_crc_error = 1'b1;
    bus.response = 48'h038765432100;
    tick();
    bus.command_complete = 1'b0; bus.command_index_error = 1'b0; bus.phy_crc_error = 1'b0;
    total++;
    if (bus.int_status !== 4'b0001 || bus.resp_reg !== 32'h12345678) begin
      bad++; $display("FAIL errors_unchecked: status=%b resp=%h want 0001 12345678", bus.int_status, bus.resp_reg);
    end
    tick();
  endtask

  task automatic test_drop();
    clear_status();
    nc_count = 0;
    issue(6'd5, 2'b10, 1'b0, 1'b0, 1'b0, 32'h000000A5);
    tick();
    bus.reg_wr_cmd = 1'b1; bus.cmd_index_in = 6'd9; bus.argument_in = 32'h99;
    tick();
    bus.reg_wr_cmd = 1'b0;
    total++;
    if (bus.cmd_dropped !== 1'b1 || bus.cmd_index !== 6'd5 || bus.cmd_argument !== 32'h000000A5) begin
      bad++; $display("FAIL drop_wait: drop=%b idx=%0d arg=%h want 1 5 000000a5",
                      bus.cmd_dropped, bus.cmd_index, bus.cmd_argument);
    end
    tick();
    total++;
    if (bus.cmd_dropped !== 1'b0) begin bad++; $display("FAIL drop_pulse_width: drop=%b want 0", bus.cmd_dropped); end
    bus.command_complete = 1'b1;
    tick();
    bus.command_complete = 1'b0;
    bus.reg_wr_cmd = 1'b1; bus.cmd_index_in = 6'd9;
    tick();
    bus.reg_wr_cmd = 1'b0;
    total++;
    if (bus.cmd_dropped !== 1'b1 || bus.cmd_inhibit !== 1'b0 || bus.new_command !== 1'b0) begin
      bad++; $display("FAIL drop_done: drop=%b inhibit=%b nc=%b want 1 0 0",
                      bus.cmd_dropped, bus.cmd_inhibit, bus.new_command);
    end
    tick();
    total++;
    if (nc_count !== 1 || bus.cmd_index !== 6'd5 || bus.cmd_inhibit !== 1'b0) begin
      bad++; $display("FAIL drop_no_launch: launches=%0d idx=%0d inhibit=%b want 1 5 0",
                      nc_count, bus.cmd_index, bus.cmd_inhibit);
    end
  endtask

  task automatic test_race();
    clear_status();
    issue(6'd12, 2'b10, 1'b0, 1'b0, 1'b1, 32'h00001234);
    repeat (TO) tick();
    bus.command_complete = 1'b1;
    bus.response = 48'h0CCAFEF00D11;
    tick();
    bus.command_complete = 1'b0;
    total++;
    if (bus.int_status !== 4'b0001 || bus.resp_reg !== 32'hCAFEF00D) begin
      bad++; $display("FAIL race_complete_wins: status=%b resp=%h want 0001 cafef00d", bus.int_status, bus.resp_reg);
    end
    tick();
    issue(6'd12, 2'b10, 1'b0, 1'b0, 1'b0, 32'h00001235);
    tick();
    bus.command_complete = 1'b1; bus.int_clr = 4'b0001;
    tick();
    bus.command_complete = 1'b0; bus.int_clr = 4'b0000;
    total++;
    if (bus.int_status !== 4'b0001) begin
      bad++; $display("FAIL set_beats_clear: status=%b want 0001", bus.int_status);
    end
    tick();
    bus.int_clr = 4'b0001;
    tick();
    bus.int_clr = 4'b0000;
    total++;
    if (bus.int_status !== 4'b0000) begin bad++; $display("FAIL w1c_clear: status=%b want 0000", bus.int_status); end
  endtask

  task automatic test_sw_rst();
    issue(6'd7, 2'b10, 1'b0, 1'b1, 1'b0, 32'h00000077);
    tick();
    bus.command_complete = 1'b1; bus.phy_crc_error = 1'b1;
    bus.response = 48'h070BADC0DE00;
    tick();
    bus.command_complete = 1'b0; bus.phy_crc_error = 1'b0;
    total++;
    if (bus.int_status !== 4'b0101) begin bad++; $display("FAIL swrst_setup: status=%b want 0101", bus.int_status); end
    tick();
    issue(6'd7, 2'b10, 1'b0, 1'b1, 1'b0, 32'h00000078);
    repeat (3) tick();
    bus.sw_rst_cmd = 1'b1;
    tick();
    bus.sw_rst_cmd = 1'b0;
    total++;
    if (bus.cmd_inhibit !== 1'b0 || bus.int_status !== 4'b0100 || bus.resp_reg !== 32'h0BADC0DE) begin
      bad++; $display("FAIL swrst_abort: inhibit=%b status=%b resp=%h want 0 0100 0badc0de",
                      bus.cmd_inhibit, bus.int_status, bus.resp_reg);
    end
    issue(6'd4, 2'b10, 1'b0, 1'b0, 1'b0, 32'h00000040);
    bus.sw_rst_cmd = 1'b1;
    #1;
    total++;
    if (bus.new_command !== 1'b0) begin bad++; $display("FAIL swrst_squash: nc=%b want 0", bus.new_command); end
    tick();
    bus.sw_rst_cmd = 1'b0;
    tick();
    total++;
    if (bus.new_command !== 1'b0 || bus.cmd_inhibit !== 1'b0) begin
      bad++; $display("FAIL swrst_idle: nc=%b inhibit=%b want 0 0", bus.new_command, bus.cmd_inhibit);
    end
    issue(6'd2, 2'b10, 1'b0, 1'b0, 1'b0, 32'h00000200);
    total++;
    if (bus.new_command !== 1'b1 || bus.cmd_index !== 6'd2) begin
      bad++; $display("FAIL swrst_relaunch: nc=%b idx=%0d want 1 2", bus.new_command, bus.cmd_index);
    end
    tick();
    bus.command_complete = 1'b1;
    bus.response = 48'h020000020000;
    tick();
    bus.command_complete = 1'b0;
    total++;
    if (bus.int_status !== 4'b0101 || bus.resp_reg !== 32'h00000200) begin
      bad++; $display("FAIL swrst_after: status=%b resp=%h want 0101 00000200", bus.int_status, bus.resp_reg);
    end
    tick();
    total++;
    if (bus.cmd_inhibit !== 1'b0) begin bad++; $display("FAIL swrst_release: inhibit=%b want 0", bus.cmd_inhibit); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_errors();
    test_drop();
    test_race();
    test_sw_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cmd_issue_ctrl.md
Name: cmd_issue_ctrl

Overview:
Sequences the SD CMD line. It accepts a software write of the command register (offset 0x00E) plus the 32-bit argument, enforces CMD inhibit, and launches one transaction on the CMD phy via new_command. It waits for completion or a watchdog timeout, checks index/CRC per the register flags, and maintains the response register and the sticky W1C status bits. It sits between the register block and the CMD phy inside SDHOST.

Parameters:
TIMEOUT_CYCLES, 64, controller clock cycles in WAIT before a timeout error is declared.
RESP_W, 48, width of the phy response bus.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-high reset.
reg_wr_cmd  in  1  one-cycle pulse: software wrote command register 0x00E.
cmd_index_in  in  6  CommandIndex field.
cmd_type_in  in  2  CommandType field; latched and not otherwise used.
data_present_in  in  1  DataPresentSelect; latched and not otherwise used.
index_check_en_in  in  1  CommandIndexCheckEnable.
crc_check_en_in  in  1  CommandCRCCheckEnable.
resp_type_in  in  2  ResponseTypeSelect: 00 none, 01 136, 10 48, 11 48+busy.
argument_in  in  32  argument register value.
timeout_en_in  in  1  enables the watchdog.
sw_rst_cmd  in  1  software reset for the CMD line (level, sampled each cycle).
int_clr  in  4  W1C strobes: [0] complete, [1] timeout, [2] crc, [3] index.
command_complete  in  1  phy completion pulse.
command_index_error  in  1  phy index mismatch, valid with command_complete.
phy_crc_error  in  1  phy CRC7 mismatch, valid with command_complete.
response  in  RESP_W  phy response frame.
new_command  out  1  one-cycle launch pulse to the phy.
cmd_argument  out  32  latched argument to the phy.
cmd_index  out  6  latched index to the phy.
timeout_enable  out  1  latched timeout_en_in to the phy.
cmd_inhibit  out  1  Present State bit 0.
resp_reg  out  32  response bits [39:8].
int_status  out  4  sticky: [0] cmd complete, [1] timeout err, [2] crc err, [3] index err.
cmd_dropped  out  1  one-cycle pulse: write rejected while inhibited.

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; watchdog clears; latched fields clear.
- FSM states: IDLE, LAUNCH, WAIT, DONE.
- IDLE, on reg_wr_cmd with cmd_inhibit=0: latch all *_in fields and the argument; next cycle the FSM is in LAUNCH and cmd_inhibit=1.
- IDLE, on reg_wr_cmd with cmd_inhibit=1: no state change; cmd_dropped=1 for the following cycle.
- LAUNCH: new_command=1 for exactly this cycle; always goes to WAIT next.
- WAIT: the watchdog starts at 0 on entry and increments each cycle, saturating at TIMEOUT_CYCLES.
- WAIT, on command_complete:
  - Set int_status[0].
  - If resp_type≠00, load resp_reg with response[39:8]; resp_type 01 and 11 are handled as 48-bit here.
  - If index_check_en=1 and command_index_error=1, set [3].
  - If crc_check_en=1 and phy_crc_error=1, set [2].
  - Go to DONE.
- WAIT, watchdog expiry: if timeout_en=1, command_complete=0 and count==TIMEOUT_CYCLES-1, set [1] only and go to DONE.
- WAIT, completion vs expiry: command_complete in the expiry cycle wins; no timeout is flagged.
- WAIT, timeout_en=0: wait indefinitely.
- DONE: for one cycle, cmd_inhibit is cleared on exit; next state is IDLE.
- Latency: a write at edge 0 gives new_command high in cycle 1. Completion sampled at edge N makes status visible from N+1 and drops cmd_inhibit at N+2. A reg_wr_cmd in DONE is dropped.
- int_status bits are sticky and cleared by the matching int_clr bit. A set and a clear in the same cycle: set wins.
- sw_rst_cmd=1: synchronous abort to IDLE; clears cmd_inhibit, watchdog and int_status[0]; error bits and resp_reg are preserved. new_command is forced 0 and any launch in flight is squashed.
- reset overrides sw_rst_cmd. sw_rst_cmd overrides reg_wr_cmd in the same cycle.
- command_complete outside WAIT is ignored.

Decomposition:
- Package sdhost_cmd_pkg holds:
  - FSM state enum;
  - RESP_NONE/RESP_136/RESP_48/RESP_48B constants;
  - INT_CMD_COMPLETE/INT_TIMEOUT/INT_CRC/INT_INDEX bit indices.
- One sub-module, cmd_watchdog: clear/enable/saturating counter with an expired flag, width $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Write index 6'd8, resp_type 10, arg 32'h000001AA; phy completes 5 cycles after the launch with response 48'h08_000001AA_01 -> new_command pulses once in cycle 1; resp_reg=32'h000001AA; int_status=4'b0001; cmd_inhibit high cycles 1..8.
- timeout_en=1, TIMEOUT_CYCLES=64, no completion -> int_status=4'b0010 after 64 WAIT cycles; resp_reg unchanged; inhibit drops 2 cycles later.
- Completion with phy_crc_error=1 and command_index_error=1, both check enables set -> int_status=4'b1101. Repeat with the enables cleared -> 4'b0001.
- Second reg_wr_cmd while inhibited -> cmd_dropped pulses; no second new_command; latched index unchanged.
- Completion and watchdog expiry in the same cycle -> 4'b0001. Then int_clr=4'b0001 in the same cycle as a new completion set -> bit remains 1.
- sw_rst_cmd mid-WAIT with int_status=4'b0101 -> state IDLE, inhibit 0, int_status=4'b0100. A subsequent write launches normally.
